// File: rtl/vec_dispatch_queue_pkg.sv
// rtl/vec_dispatch_queue_pkg.sv - shared constants and entry/response types for the vector dispatch queue
package vec_dispatch_queue_pkg;

  localparam int unsigned VDQ_DEPTH      = 4;
  localparam int unsigned VDQ_XLEN       = 64;
  localparam int unsigned VDQ_TRANS_ID_W = 3;
  localparam int unsigned VDQ_INSN_W     = 32;

  typedef struct packed {
    logic [VDQ_INSN_W-1:0]     insn;
    logic [VDQ_XLEN-1:0]       rs1;
    logic [VDQ_XLEN-1:0]       rs2;
    logic [VDQ_TRANS_ID_W-1:0] trans_id;
  } vec_dispatch_entry_t;

  typedef struct packed {
    logic [VDQ_TRANS_ID_W-1:0] trans_id;
    logic [VDQ_XLEN-1:0]       result;
    logic                      error;
  } vec_resp_t;

endpackage

// File: rtl/vec_dispatch_queue_if.sv
// rtl/vec_dispatch_queue_if.sv - issue, accelerator request/response and writeback signal bundle
interface vec_dispatch_queue_if
  import vec_dispatch_queue_pkg::*;
#(
  parameter int unsigned XLEN       = VDQ_XLEN,
  parameter int unsigned TRANS_ID_W = VDQ_TRANS_ID_W
);

  logic                  flush_i;
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [VDQ_INSN_W-1:0] issue_insn_i;
  logic [TRANS_ID_W-1:0] issue_trans_id_i;
  logic [XLEN-1:0]       issue_rs1_i;
  logic [XLEN-1:0]       issue_rs2_i;
  logic                  acc_req_valid_o;
  logic                  acc_req_ready_i;
  logic [VDQ_INSN_W-1:0] acc_req_insn_o;
  logic [XLEN-1:0]       acc_req_rs1_o;
  logic [XLEN-1:0]       acc_req_rs2_o;
  logic [TRANS_ID_W-1:0] acc_req_trans_id_o;
  logic                  acc_resp_valid_i;
  logic [TRANS_ID_W-1:0] acc_resp_trans_id_i;
  logic [XLEN-1:0]       acc_resp_result_i;
  logic                  acc_resp_error_i;
  logic                  wb_valid_o;
  logic [TRANS_ID_W-1:0] wb_trans_id_o;
  logic [XLEN-1:0]       wb_result_o;
  logic                  wb_ex_valid_o;
  logic                  resp_mismatch_o;
  logic                  empty_o;

  modport slave (
    input  flush_i, issue_valid_i, issue_insn_i, issue_trans_id_i, issue_rs1_i, issue_rs2_i,
           acc_req_ready_i, acc_resp_valid_i, acc_resp_trans_id_i, acc_resp_result_i,
           acc_resp_error_i,
    output issue_ready_o, acc_req_valid_o, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o,
           acc_req_trans_id_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o,
           resp_mismatch_o, empty_o
  );

  modport master (
    output flush_i, issue_valid_i, issue_insn_i, issue_trans_id_i, issue_rs1_i, issue_rs2_i,
           acc_req_ready_i, acc_resp_valid_i, acc_resp_trans_id_i, acc_resp_result_i,
           acc_resp_error_i,
    input  issue_ready_o, acc_req_valid_o, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o,
           acc_req_trans_id_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o,
           resp_mismatch_o, empty_o
  );

endinterface

// File: rtl/vec_dispatch_queue.sv
// rtl/vec_dispatch_queue.sv - in-order issue-to-vector-unit buffer with retire-ordered writeback
module vec_dispatch_queue
  import vec_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = VDQ_DEPTH,
  parameter int unsigned XLEN       = VDQ_XLEN,
  parameter int unsigned TRANS_ID_W = VDQ_TRANS_ID_W
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  vec_dispatch_queue_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic [VDQ_INSN_W-1:0] insn;
    logic [XLEN-1:0]       rs1;
    logic [XLEN-1:0]       rs2;
    logic [TRANS_ID_W-1:0] trans_id;
  } entry_t;

  entry_t                entries_q [DEPTH];
  entry_t                entries_d [DEPTH];
  ptr_t                  wr_q, wr_d;
  ptr_t                  disp_q, disp_d;
  ptr_t                  ret_q, ret_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [TRANS_ID_W-1:0] wb_trans_id_q, wb_trans_id_d;
  logic [XLEN-1:0]       wb_result_q, wb_result_d;
  logic                  wb_ex_q, wb_ex_d;
  logic                  mismatch_q, mismatch_d;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  ptr_t   n_pend, n_fly, occupancy;
  logic   issue_ready, req_valid, issue_fire, req_fire, retire;
  entry_t disp_entry, ret_entry;

  assign n_pend     = wr_q - disp_q;
  assign n_fly      = disp_q - ret_q;
  assign occupancy  = wr_q - ret_q;
  assign disp_entry = entries_q[disp_q[IDX_W-1:0]];
  assign ret_entry  = entries_q[ret_q[IDX_W-1:0]];

  assign issue_ready = (occupancy < ptr_t'(DEPTH)) && !bus.flush_i;
  assign req_valid   = (n_pend != '0);
  assign issue_fire  = bus.issue_valid_i && issue_ready;
  assign req_fire    = req_valid && bus.acc_req_ready_i;
  assign retire      = bus.acc_resp_valid_i && (n_fly != '0);

  always_comb begin
    entries_d     = entries_q;
    disp_d        = disp_q + ptr_t'(req_fire);
    wr_d          = wr_q + ptr_t'(issue_fire);
    ret_d         = ret_q + ptr_t'(retire);
    wb_valid_d    = retire;
    wb_ex_d       = retire && bus.acc_resp_error_i;
    wb_trans_id_d = wb_trans_id_q;
    wb_result_d   = wb_result_q;
    mismatch_d    = mismatch_q;

    if (issue_fire) begin
      entries_d[wr_q[IDX_W-1:0]] = '{insn:     bus.issue_insn_i,
                                     rs1:      bus.issue_rs1_i,
                                     rs2:      bus.issue_rs2_i,
                                     trans_id: bus.issue_trans_id_i};
    end

    // Flush drops only undispatched work; a request accepted this cycle is already in flight.
    if (bus.flush_i) begin
      wr_d = disp_d;
    end

    if (retire) begin
      wb_trans_id_d = ret_entry.trans_id;
      wb_result_d   = bus.acc_resp_result_i;
      if (bus.acc_resp_trans_id_i != ret_entry.trans_id) begin
        mismatch_d = 1'b1;
      end
    end else if (bus.acc_resp_valid_i) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      wr_q          <= '0;
      disp_q        <= '0;
      ret_q         <= '0;
      wb_valid_q    <= 1'b0;
      wb_trans_id_q <= '0;
      wb_result_q   <= '0;
      wb_ex_q       <= 1'b0;
      mismatch_q    <= 1'b0;
    end else begin
      entries_q     <= entries_d;
      wr_q          <= wr_d;
      disp_q        <= disp_d;
      ret_q         <= ret_d;
      wb_valid_q    <= wb_valid_d;
      wb_trans_id_q <= wb_trans_id_d;
      wb_result_q   <= wb_result_d;
      wb_ex_q       <= wb_ex_d;
      mismatch_q    <= mismatch_d;
    end
  end

  assign bus.issue_ready_o      = issue_ready;
  assign bus.acc_req_valid_o    = req_valid;
  assign bus.acc_req_insn_o     = req_valid ? disp_entry.insn : '0;
  assign bus.acc_req_rs1_o      = req_valid ? disp_entry.rs1 : '0;
  assign bus.acc_req_rs2_o      = req_valid ? disp_entry.rs2 : '0;
  assign bus.acc_req_trans_id_o = req_valid ? disp_entry.trans_id : '0;
  assign bus.wb_valid_o         = wb_valid_q;
  assign bus.wb_trans_id_o      = wb_trans_id_q;
  assign bus.wb_result_o        = wb_result_q;
  assign bus.wb_ex_valid_o      = wb_ex_q;
  assign bus.resp_mismatch_o    = mismatch_q;
  assign bus.empty_o            = (occupancy == '0);

endmodule
